nw_border_init_sequencer: RTL
=============================

Name: nw_border_init_sequencer

Overview:
Sequences the initialisation of the Needleman-Wunsch score and direction RAMs. It writes the first row and the first column of the (N+1)x(N+1) matrix, alternating row and column writes. Score values are idx*GAP, and direction codes mark each border cell's origin. It sits between the top-level NW control FSM (start/done) and the shared RAM write port, which it drives through a ready-qualified write handshake.

Parameters:
N, 8, sequence length; matrix is (N+1)x(N+1), row-major, row 0 at addresses 0..N.
ADDR_W, 7, address width; must satisfy 2^ADDR_W >= (N+1)^2.
DATA_W, 8, signed score width; must hold N*|GAP| without overflow (no saturation).
GAP, -2, signed gap penalty.

Ports:
clk  input  1  clock, rising-edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  request to run one init pass; sampled only in IDLE.
ready  input  1  RAM write port accepts a write this cycle.
busy  output  1  high from the first write cycle through the DONE cycle.
done  output  1  one-cycle pulse after the last accepted write.
we  output  1  write request to the score and direction RAMs.
addr  output  ADDR_W  matrix address of the current write.
score_data  output  DATA_W  signed score to write.
dir_data  output  2  direction code: 00 origin, 01 up (column cell), 10 left (row cell), 11 unused.
col_phase  output  1  0 = row write, 1 = column write.

Behaviour:
- Reset (async, any state): state=IDLE, idx=0; all outputs 0.
- All outputs are registered and derived from state, idx and accumulators. No combinational paths from inputs to outputs.
- States: IDLE, ROW, COL, FIN.
- IDLE:
  - start=1 at an edge -> ROW with idx=0, busy=1.
  - start=0 -> stay in IDLE.
- ROW:
  - Outputs: we=1, col_phase=0, addr=idx, score_data=idx*GAP.
  - dir_data = 00 when idx=0, else 10.
- COL:
  - Outputs: we=1, col_phase=1, addr=idx*(N+1), score_data=idx*GAP, dir_data=01.
- Write acceptance:
  - A write is accepted at an edge where we&&ready.
  - When ready=0, state and all outputs hold unchanged. This is an unbounded stall.
- Transitions on acceptance:
  - ROW, idx=0 -> ROW, idx=1. The origin is written once and column cell 0 is skipped.
  - ROW, idx>0 -> COL, same idx.
  - COL, idx<N -> ROW, idx+1.
  - COL, idx=N -> FIN.
- Write count and ordering:
  - Exactly 2N+1 writes per pass.
  - Order: 0, 1, N+1, 2, 2(N+1), ..., N, N(N+1).
- FIN:
  - Outputs: we=0, done=1, busy=1 for one cycle.
  - Then -> IDLE with busy=0 and done=0.
- Arithmetic:
  - score_data and the column address are accumulators, not multipliers.
  - Per idx increment: score accumulator += GAP (signed, DATA_W wide) and column-address accumulator += N+1.
  - Both accumulators clear on entry from IDLE.
- Boundary conditions:
  - start while busy (ROW/COL/FIN): ignored; no queuing.
  - start held high through FIN: sampled in the following IDLE cycle, so a new pass starts 2 cycles after done.
  - N=1: writes 0, 1, 2, then FIN.
  - rst asserted mid-pass: immediate abort, we=0, no done pulse. The partially written RAM is the requester's responsibility.
  - ready is ignored in IDLE and FIN.

Test Plan:
- N=4, GAP=-2, ready=1, single start pulse -> 9 consecutive we cycles beginning 1 cycle after start.
  - addr 0,1,5,2,10,3,15,4,20
  - score 0,-2,-2,-4,-4,-6,-6,-8,-8
  - dir 00,10,01,10,01,10,01,10,01
  - done pulses on cycle 10 after start; busy high cycles 1..10.
- Same config, ready=0 for 3 cycles while addr=5 -> addr/score/dir/we held for 3 cycles; the sequence then resumes unchanged and done is delayed by exactly 3 cycles.
- start pulsed again while addr=10 -> no effect: still 9 writes total, and one done pulse.
- rst asserted while addr=3, then deasserted -> we, busy and done are 0 immediately and stay 0; a later start produces the full 9-write sequence from addr 0.
- start held high continuously -> passes repeat; the next pass's first write (addr 0) appears 2 cycles after each done.
- N=1, GAP=-3 -> writes (addr,score,dir) = (0,0,00), (1,-3,10), (2,-3,01), then done.

Source files
------------

// File: rtl/nw_border_init_sequencer.sv
// Border initialisation for the Needleman-Wunsch score/direction RAMs: writes row 0 and
// column 0 of the (N+1)x(N+1) matrix, interleaving row and column cells, over a ready-qualified port.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | waiting for start; all outputs low
// S_ROW  | presenting row-0 cell idx (addr = idx)
// S_COL  | presenting column-0 cell idx (addr = idx*(N+1))
// S_FIN  | one-cycle done pulse, no write
module nw_border_init_sequencer #(
   parameter int N      = 8,
   parameter int ADDR_W = 7,
   parameter int DATA_W = 8,
   parameter int GAP    = -2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     ready,
   output logic                     busy,
   output logic                     done,
   output logic                     we,
   output logic [ADDR_W-1:0]        addr,
   output logic signed [DATA_W-1:0] score_data,
   output logic [1:0]               dir_data,
   output logic                     col_phase
);

   localparam int IDX_W = (N < 2) ? 1 : $clog2(N + 1);
   localparam logic [IDX_W-1:0]         IDX_LAST   = IDX_W'(N);
   localparam logic [IDX_W-1:0]         IDX_ONE    = IDX_W'(1);
   localparam logic [ADDR_W-1:0]        COL_STRIDE = ADDR_W'(N + 1);
   localparam logic signed [DATA_W-1:0] GAP_D      = DATA_W'(GAP);

   localparam logic [1:0] DIR_ORIGIN = 2'b00;
   localparam logic [1:0] DIR_UP     = 2'b01;
   localparam logic [1:0] DIR_LEFT   = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ROW  = 2'd1,
      S_COL  = 2'd2,
      S_FIN  = 2'd3
   } state_t;

   state_t                     state, state_n;
   logic [IDX_W-1:0]           idx, idx_n;
   logic signed [DATA_W-1:0]   score_acc, score_acc_n;
   logic [ADDR_W-1:0]          col_acc, col_acc_n;

   logic                       busy_n, done_n, we_n, col_phase_n;
   logic [ADDR_W-1:0]          addr_n;
   logic signed [DATA_W-1:0]   score_n;
   logic [1:0]                 dir_n;

   // Next-state and accumulator update. Both accumulators step together with idx
   // so they always equal idx*GAP and idx*(N+1) without a multiplier.
   always_comb begin
      state_n     = state;
      idx_n       = idx;
      score_acc_n = score_acc;
      col_acc_n   = col_acc;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_n     = S_ROW;
               idx_n       = '0;
               score_acc_n = '0;
               col_acc_n   = '0;
            end
         end
         S_ROW: begin
            if (ready) begin
               if (idx == '0) begin
                  // origin doubles as column cell 0, so go straight to row cell 1
                  idx_n       = idx + IDX_ONE;
                  score_acc_n = score_acc + GAP_D;
                  col_acc_n   = col_acc + COL_STRIDE;
               end else begin
                  state_n = S_COL;
               end
            end
         end
         S_COL: begin
            if (ready) begin
               if (idx == IDX_LAST) begin
                  state_n = S_FIN;
               end else begin
                  state_n     = S_ROW;
                  idx_n       = idx + IDX_ONE;
                  score_acc_n = score_acc + GAP_D;
                  col_acc_n   = col_acc + COL_STRIDE;
               end
            end
         end
         S_FIN: begin
            state_n = S_IDLE;
         end
         default: begin
            state_n = S_IDLE;
         end
      endcase
   end

   // Output values for the next cycle, decoded from the next-state view so the
   // registered outputs line up with the state they describe.
   always_comb begin
      we_n        = (state_n == S_ROW) || (state_n == S_COL);
      col_phase_n = (state_n == S_COL);
      busy_n      = (state_n != S_IDLE);
      done_n      = (state_n == S_FIN);
      addr_n      = '0;
      score_n     = '0;
      dir_n       = DIR_ORIGIN;
      case (state_n)
         S_ROW: begin
            addr_n  = ADDR_W'(idx_n);
            score_n = score_acc_n;
            dir_n   = (idx_n == '0) ? DIR_ORIGIN : DIR_LEFT;
         end
         S_COL: begin
            addr_n  = col_acc_n;
            score_n = score_acc_n;
            dir_n   = DIR_UP;
         end
         default: begin
            addr_n  = '0;
            score_n = '0;
            dir_n   = DIR_ORIGIN;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         idx        <= '0;
         score_acc  <= '0;
         col_acc    <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         we         <= 1'b0;
         addr       <= '0;
         score_data <= '0;
         dir_data   <= DIR_ORIGIN;
         col_phase  <= 1'b0;
      end else begin
         state      <= state_n;
         idx        <= idx_n;
         score_acc  <= score_acc_n;
         col_acc    <= col_acc_n;
         busy       <= busy_n;
         done       <= done_n;
         we         <= we_n;
         addr       <= addr_n;
         score_data <= score_n;
         dir_data   <= dir_n;
         col_phase  <= col_phase_n;
      end
   end

endmodule
